// File: rtl/text_cell_sequencer.sv
// rtl/text_cell_sequencer.sv - walks a row of text cells and issues one glyph request per cell
// Optional buffer-clear engine enabled by defining TEXT_CLEAR_EN.
module text_cell_sequencer #(
  parameter logic [9:0] X_ORIGIN  = 10'd100,
  parameter logic [9:0] Y_ORIGIN  = 10'd200,
  parameter int         CELL_W    = 24,
  parameter int         CELL_H    = 21,
  parameter int         NUM_CELLS = 16
) (
  input  logic       VGA_clk,
  input  logic       resetn,
  input  logic [9:0] xPixel,
  input  logic [9:0] yPixel,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       clr,
  output logic [7:0] ascii_val,
  output logic [9:0] xStart,
  output logic [9:0] yStart,
  output logic       cell_valid
);

  localparam int COL_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int SUB_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_CELLS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_W - 1);
  localparam logic [9:0]       Y_END    = Y_ORIGIN + 10'(CELL_H);
  localparam logic [9:0]       CELL_W10 = 10'(CELL_W);

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ROW   = 2'd1,
`ifdef TEXT_CLEAR_EN
    S_SCAN  = 2'd2,
    S_CLEAR = 2'd3
`else
    S_SCAN  = 2'd2
`endif
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [COL_W-1:0] col;
  logic [SUB_W-1:0] sub;
  logic [7:0]       char_buf [NUM_CELLS];
  logic             band_ok;
  logic             wr_commit;

`ifdef TEXT_CLEAR_EN
  logic [COL_W-1:0] clr_idx;
  logic             band_hold;

  // A band start that coincides with a clear is skipped until the next frame.
  assign band_ok = !band_hold;

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      clr_idx   <= '0;
      band_hold <= 1'b0;
    end else begin
      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
      else                  clr_idx <= '0;
      if (state == S_CLEAR && yPixel == Y_ORIGIN) band_hold <= 1'b1;
      else if (yPixel != Y_ORIGIN)                band_hold <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign band_ok    = 1'b1;
`endif

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) state <= S_BLANK;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_BLANK: begin
`ifdef TEXT_CLEAR_EN
        if (clr)                                      state_next = S_CLEAR;
        else if (yPixel == Y_ORIGIN && band_ok)       state_next = S_ROW;
`else
        if (yPixel == Y_ORIGIN && band_ok)            state_next = S_ROW;
`endif
      end
      S_ROW: begin
        if (yPixel == Y_END)                          state_next = S_BLANK;
        else if (xPixel == X_ORIGIN)                  state_next = S_SCAN;
      end
      S_SCAN: begin
        if (yPixel == Y_END)                          state_next = S_BLANK;
        else if ((col == COL_LAST && sub == SUB_LAST) || xPixel < X_ORIGIN)
                                                      state_next = S_ROW;
      end
`ifdef TEXT_CLEAR_EN
      S_CLEAR: begin
        if (clr_idx == COL_LAST)                      state_next = S_BLANK;
      end
`endif
      default:                                        state_next = S_BLANK;
    endcase
  end

  assign wr_ready = (state == S_BLANK);
  // A write on the same edge that leaves S_BLANK is dropped.
  assign wr_commit = wr_en && wr_ready && (state_next == S_BLANK);

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CELLS; i++) char_buf[i] <= 8'h20;
    end else begin
`ifdef TEXT_CLEAR_EN
      if (state == S_CLEAR) char_buf[clr_idx] <= 8'h20;
      else if (wr_commit)   char_buf[wr_addr] <= wr_data;
`else
      if (wr_commit)        char_buf[wr_addr] <= wr_data;
`endif
    end
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      col        <= '0;
      sub        <= '0;
      ascii_val  <= 8'h00;
      xStart     <= 10'd0;
      yStart     <= 10'd0;
      cell_valid <= 1'b0;
    end else begin
      if (state == S_SCAN) begin
        ascii_val  <= char_buf[col];
        xStart     <= X_ORIGIN + 10'(col) * CELL_W10;
        yStart     <= Y_ORIGIN;
        cell_valid <= 1'b1;
      end else begin
        ascii_val  <= 8'h00;
        cell_valid <= 1'b0;
      end
      if (state == S_ROW && xPixel == X_ORIGIN) begin
        col <= '0;
        sub <= '0;
      end else if (state == S_SCAN) begin
        if (sub == SUB_LAST) begin
          sub <= '0;
          col <= col + 1'b1;
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end

endmodule
